lock_monitor: RTL and testbench

//  Watches a loop error/monitor signal against a programmable window and produces the debounced
//  out_of_lock flag. That flag drives the relock controller's out_of_lock input, and its state

---
 rtl/lock_monitor.sv | 168 ++++++++++++++++
 tb/tb_lock_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_monitor.sv
// rtl/lock_monitor.sv - debounced loop lock monitor with unlock event counter
//
// Purpose:
//   Registers a signed inclusive window comparison of the monitored signal.
//   A debounce FSM then turns the registered comparison into a stable
//   out_of_lock flag for the relock controller. The flag cannot chatter
//   while a relock scan sweeps through the lock point. The block also
//   counts lock-loss events and exports its state for the debug mux.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset
//   enable          1 = monitor active, 0 = forced to DISABLED
//   clear           synchronous clear of unlock_events
//   signal          signed monitored value (R bits)
//   thr_low         signed lower window limit, inclusive (R bits)
//   thr_hig         signed upper window limit, inclusive (R bits)
//   unlock_cnt_max  consecutive out-of-window samples to declare unlock (CW bits)
//   lock_cnt_max    consecutive in-window samples to declare lock (CW bits)
//   out_of_lock     1 in UNLOCKED and REGAIN
//   in_window       registered window comparison
//   unlock_events   saturating count of lock-loss events (16 bits)
//   state_mon       {1'b0, state, zeros} for the debug mux (R bits)

module lock_monitor #(
   parameter int R  = 14,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          clear,
   input  logic [R-1:0]  signal,
   input  logic [R-1:0]  thr_low,
   input  logic [R-1:0]  thr_hig,
   input  logic [CW-1:0] unlock_cnt_max,
   input  logic [CW-1:0] lock_cnt_max,
   output logic          out_of_lock,
   output logic          in_window,
   output logic [15:0]   unlock_events,
   output logic [R-1:0]  state_mon
);

   typedef enum logic [2:0] {
      ST_DISABLED = 3'd0,
      ST_LOCKED   = 3'd1,
      ST_SUSPECT  = 3'd2,
      ST_UNLOCKED = 3'd3,
      ST_REGAIN   = 3'd4
   } state_t;

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          event_inc;
   logic [CW-1:0] n_eff, m_eff;
   logic [CW:0]   cnt_inc;
   logic [CW-1:0] cnt_sat;
   logic          window_hit;

   // An inverted window (thr_low > thr_hig) can never satisfy both compares.
   assign window_hit = ($signed(signal) >= $signed(thr_low)) &&
                       ($signed(signal) <= $signed(thr_hig));

   // A limit of zero behaves as one so that a single sample always decides.
   assign n_eff   = (unlock_cnt_max == '0) ? CNT_ONE : unlock_cnt_max;
   assign m_eff   = (lock_cnt_max == '0) ? CNT_ONE : lock_cnt_max;
   assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
   assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt_inc[CW-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_window <= 1'b0;
         state     <= ST_DISABLED;
         cnt       <= '0;
      end else begin
         in_window <= window_hit;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      event_inc = 1'b0;
      if (!enable) begin
         state_nxt = ST_DISABLED;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_DISABLED: begin
               state_nxt = ST_LOCKED;
               cnt_nxt   = '0;
            end
            ST_LOCKED: begin
               if (in_window) begin
                  cnt_nxt = '0;
               end else if (n_eff == CNT_ONE) begin
                  state_nxt = ST_UNLOCKED;
                  cnt_nxt   = '0;
                  event_inc = 1'b1;
               end else begin
                  state_nxt = ST_SUSPECT;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_SUSPECT: begin
               if (in_window) begin
                  state_nxt = ST_LOCKED;
                  cnt_nxt   = '0;
               end else if (cnt_inc >= {1'b0, n_eff}) begin
                  state_nxt = ST_UNLOCKED;
                  cnt_nxt   = '0;
                  event_inc = 1'b1;
               end else begin
                  cnt_nxt = cnt_sat;
               end
            end
            ST_UNLOCKED: begin
               if (!in_window) begin
                  cnt_nxt = '0;
               end else if (m_eff == CNT_ONE) begin
                  state_nxt = ST_LOCKED;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ST_REGAIN;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_REGAIN: begin
               // Falling back from REGAIN is not a new lock loss: no event.
               if (!in_window) begin
                  state_nxt = ST_UNLOCKED;
                  cnt_nxt   = '0;
               end else if (cnt_inc >= {1'b0, m_eff}) begin
                  state_nxt = ST_LOCKED;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_sat;
               end
            end
            default: begin
               state_nxt = ST_DISABLED;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Clear takes precedence over a simultaneous lock-loss increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         unlock_events <= 16'h0000;
      end else if (clear) begin
         unlock_events <= 16'h0000;
      end else if (event_inc && (unlock_events != 16'hFFFF)) begin
         unlock_events <= unlock_events + 16'h0001;
      end
   end

   // Decoded from the state register alone, so it cannot glitch on input changes.
   assign out_of_lock = (state == ST_UNLOCKED) || (state == ST_REGAIN);
   assign state_mon   = {1'b0, state, {(R-4){1'b0}}};

endmodule

// File: tb/tb_lock_monitor.sv
// tb/tb_lock_monitor.sv - self-checking bench for lock_monitor
module tb_lock_monitor;

   logic               clk;
   logic               rst;
   logic               enable;
   logic               clear;
   logic signed [13:0] sig;
   logic signed [13:0] thr_lo;
   logic signed [13:0] thr_hi;
   logic [15:0]        ncnt;
   logic [15:0]        mcnt;
   logic               oob;
   logic               iw;
   logic [15:0]        events;
   logic [13:0]        smon;

   int tests = 0;
   int fails = 0;

   // Reference model: run-length view of the debounce rules.
   bit m_dis;
   bit m_lost;
   bit m_iw;
   int m_run;
   int m_events;

   lock_monitor #(.R(14), .CW(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .clear          (clear),
      .signal         (sig),
      .thr_low        (thr_lo),
      .thr_hig        (thr_hi),
      .unlock_cnt_max (ncnt),
      .lock_cnt_max   (mcnt),
      .out_of_lock    (oob),
      .in_window      (iw),
      .unlock_events  (events),
      .state_mon      (smon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dis    = 1'b1;
      m_lost   = 1'b0;
      m_iw     = 1'b0;
      m_run    = 0;
      m_events = 0;
   endtask

   task automatic model_edge();
      int  neff;
      int  meff;
      bit  ev;
      neff = (ncnt == 16'd0) ? 1 : int'(ncnt);
      meff = (mcnt == 16'd0) ? 1 : int'(mcnt);
      ev   = 1'b0;
      if (!rst) begin
         model_reset();
         return;
      end
      if (!enable) begin
         m_dis  = 1'b1;
         m_lost = 1'b0;
         m_run  = 0;
      end else if (m_dis) begin
         m_dis  = 1'b0;
         m_lost = 1'b0;
         m_run  = 0;
      end else if (!m_lost) begin
         m_run = m_iw ? 0 : m_run + 1;
         if (m_run >= neff) begin
            m_lost = 1'b1;
            m_run  = 0;
            ev     = 1'b1;
         end
      end else begin
         m_run = m_iw ? m_run + 1 : 0;
         if (m_run >= meff) begin
            m_lost = 1'b0;
            m_run  = 0;
         end
      end
      if (clear) m_events = 0;
      else if (ev && m_events < 65535) m_events++;
      m_iw = (int'(sig) >= int'(thr_lo)) && (int'(sig) <= int'(thr_hi));
   endtask

   function automatic logic [13:0] exp_smon();
      logic [2:0] code;
      if (m_dis)        code = 3'd0;
      else if (!m_lost) code = (m_run == 0) ? 3'd1 : 3'd2;
      else              code = (m_run == 0) ? 3'd3 : 3'd4;
      return {1'b0, code, 10'b0};
   endfunction

   task automatic check_all();
      logic [15:0] ev_exp;
      ev_exp = m_events[15:0];
      chk("in_window", {31'b0, iw}, {31'b0, m_iw});
      chk("out_of_lock", {31'b0, oob}, {31'b0, (!m_dis && m_lost)});
      chk("unlock_events", {16'b0, events}, {16'b0, ev_exp});
      chk("state_mon", {18'b0, smon}, {18'b0, exp_smon()});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int v;
      rst    = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      sig    = 14'sd0;
      thr_lo = -14'sd100;
      thr_hi = 14'sd100;
      ncnt   = 16'd4;
      mcnt   = 16'd3;
      model_reset();
      #2;
      check_all();
      step();
      step();
      rst    = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("locked_after_enable", {18'b0, smon}, 32'h0400);

      // Sustained excursion: flag rises exactly after edge e+4.
      sig = 14'sd200;
      for (int k = 0; k <= 4; k++) begin
         step();
         chk("unlock_latency", {31'b0, oob}, {31'b0, (k == 4)});
      end
      chk("first_event", {16'b0, events}, 32'd1);

      // Regain interrupted by one out-of-window sample.
      sig = 14'sd0;   step();
      sig = 14'sd0;   step();
      sig = 14'sd200; step();
      sig = 14'sd0;   step();
      step();
      step();
      chk("regain_pending", {31'b0, oob}, 32'd1);
      step();
      chk("regain_done", {31'b0, oob}, 32'd0);
      chk("regain_no_event", {16'b0, events}, 32'd1);

      // Three-sample glitch is rejected with N=4.
      for (int k = 0; k < 6; k++) begin
         sig = (k < 3) ? 14'sd200 : 14'sd0;
         step();
         chk("glitch_oob", {31'b0, oob}, 32'd0);
      end
      chk("glitch_locked", {18'b0, smon}, 32'h0400);
      chk("glitch_events", {16'b0, events}, 32'd1);

      // Window boundaries.
      sig = 14'sd100; step();
      chk("edge_hi_in", {31'b0, iw}, 32'd1);
      sig = 14'sd101; step();
      chk("edge_hi_out", {31'b0, iw}, 32'd0);
      thr_lo = 14'sd50; thr_hi = -14'sd50; sig = 14'sd0; step();
      chk("empty_window", {31'b0, iw}, 32'd0);
      thr_lo = -14'sd100; thr_hi = 14'sd100;
      for (int k = 0; k < 8; k++) step();
      chk("relocked", {31'b0, oob}, 32'd0);
      ncnt = 16'd0;
      sig = 14'sd200; step();
      chk("n0_edge_e", {31'b0, oob}, 32'd0);
      step();
      chk("n0_edge_e1", {31'b0, oob}, 32'd1);
      thr_lo = 14'h2000; thr_hi = 14'sd0; sig = 14'h2000; step();
      chk("min_value_in", {31'b0, iw}, 32'd1);
      thr_lo = -14'sd100; thr_hi = 14'sd100; sig = 14'sd0; ncnt = 16'd4;
      for (int k = 0; k < 6; k++) step();

      // Disable from SUSPECT with cnt=2, then re-enable.
      sig = 14'sd200; step(); step(); step();
      chk("suspect_cnt2", {18'b0, smon}, 32'h0800);
      enable = 1'b0; step();
      chk("disabled_state", {18'b0, smon}, 32'h0000);
      chk("disabled_oob", {31'b0, oob}, 32'd0);
      enable = 1'b1; sig = 14'sd0; step();
      chk("reenabled", {18'b0, smon}, 32'h0400);
      step();

      // Saturation of the event counter from a preset near the top.
      ncnt = 16'd1; mcnt = 16'd1;
      @(negedge clk);
      force dut.unlock_events = 16'hFFFD;
      #1;
      release dut.unlock_events;
      m_events = 32'hFFFD;
      for (int k = 0; k < 10; k++) begin
         sig = (k % 2 == 0) ? 14'sd200 : 14'sd0;
         step();
      end
      chk("events_saturate", {16'b0, events}, 32'hFFFF);
      sig = 14'sd0; step(); step();
      sig = 14'sd200; step();
      clear = 1'b1; step();
      clear = 1'b0;
      chk("clear_wins", {16'b0, events}, 32'd0);
      chk("clear_unlocked", {31'b0, oob}, 32'd1);
      sig = 14'sd0; step(); step();

      // Randomized phase against the model.
      for (int i = 0; i < 800; i++) begin
         enable = ($urandom_range(39) != 0);
         clear  = ($urandom_range(59) == 0);
         if ($urandom_range(30) == 0) ncnt = 16'($urandom_range(5));
         if ($urandom_range(30) == 0) mcnt = 16'($urandom_range(5));
         if ($urandom_range(60) == 0) begin
            v = int'($urandom_range(400)) - 200; thr_lo = v[13:0];
            v = int'($urandom_range(400)) - 200; thr_hi = v[13:0];
         end
         if ($urandom_range(3) == 0) begin
            v = int'($urandom_range(600)) - 300;
            sig = v[13:0];
         end
         step();
      end
      clear = 1'b0;
      enable = 1'b1;

      // Async reset mid-SUSPECT with a nonzero event count.
      thr_lo = -14'sd100; thr_hi = 14'sd100; ncnt = 16'd1; mcnt = 16'd1;
      sig = 14'sd0;   for (int k = 0; k < 4; k++) step();
      sig = 14'sd200; step(); step();
      sig = 14'sd0;   step(); step();
      ncnt = 16'd4;
      sig = 14'sd200; step(); step();
      chk("pre_reset_suspect", {18'b0, smon}, 32'h0800);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_oob", {31'b0, oob}, 32'd0);
      chk("async_iw", {31'b0, iw}, 32'd0);
      chk("async_events", {16'b0, events}, 32'd0);
      chk("async_state", {18'b0, smon}, 32'd0);
      step();
      rst = 1'b1;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
